// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI-style bus target serving single and burst memory reads/writes from a small word array.
// Latency: fast decode, DEVSEL/TRDY the cycle after the address phase; reads insert one AD turnaround cycle first.
// Backpressure: IRDY high inserts wait states; a burst running past the last word is disconnected with STOP.
module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0010,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    inout  wire  [31:0] AD,
    input  logic [3:0]  C_BE,
    input  logic        Frame,
    input  logic        IRDY,
    output wire         TRDY,
    output wire         DEVSEL,
    output wire         STOP
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BUSY    = 3'd1;
    localparam logic [2:0] ST_W_DATA  = 3'd2;
    localparam logic [2:0] ST_R_TURN  = 3'd3;
    localparam logic [2:0] ST_R_DATA  = 3'd4;
    localparam logic [2:0] ST_DISC    = 3'd5;
    localparam logic [2:0] ST_BACKOFF = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          frame_q;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   addr_off;
    logic          addr_phase;
    logic          is_rd, is_wr, hit;
    logic          last_word;
    logic          wr_en;
    logic          ctl_oe;

    // Address decode. The unsigned offset wraps to a huge value for addresses
    // below BASE_ADDR, so a single upper-bound compare covers both ends.
    assign addr_off   = AD - BASE_ADDR;
    assign addr_phase = (state_q == ST_IDLE) && !Frame && frame_q;
    assign is_rd      = (C_BE == CMD_MEM_READ);
    assign is_wr      = (C_BE == CMD_MEM_WRITE);
    assign hit        = (is_rd || is_wr) && (AD[1:0] == 2'b00) && (addr_off < SPAN);
    assign last_word  = (idx_q == IW'(DEPTH - 1));

    // Next-state, word index and write strobe for the bus protocol.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_phase) begin
                    idx_d = addr_off[IW+1:2];
                    if (hit && is_wr)      state_d = ST_W_DATA;
                    else if (hit && is_rd) state_d = ST_R_TURN;
                    else                   state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (Frame && IRDY) state_d = ST_IDLE;
            end
            ST_W_DATA, ST_R_DATA: begin
                // TRDY is always asserted here, so IRDY alone completes a transfer.
                if (!IRDY) begin
                    wr_en = (state_q == ST_W_DATA);
                    idx_d = idx_q + IW'(1);
                    // A last transfer (Frame high) always ends normally, even on the final word.
                    if (Frame)          state_d = ST_BACKOFF;
                    else if (last_word) state_d = ST_DISC;
                end
            end
            ST_R_TURN: begin
                state_d = ST_R_DATA;
            end
            ST_DISC: begin
                if (Frame) state_d = ST_BACKOFF;
            end
            ST_BACKOFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Protocol state, index and the Frame history used to find the falling edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            frame_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= Frame;
        end
    end

    // Memory array: cleared on reset, byte-masked write on each completed write transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (!C_BE[b]) begin
                    mem_q[idx_q][8*b +: 8] <= AD[8*b +: 8];
                end
            end
        end
    end

    // Bus drivers are decoded straight from state so reset releases them without waiting for a clock.
    assign ctl_oe = (state_q == ST_W_DATA) || (state_q == ST_R_TURN) || (state_q == ST_R_DATA) ||
                    (state_q == ST_DISC)   || (state_q == ST_BACKOFF);

    assign TRDY   = ctl_oe ? !((state_q == ST_W_DATA) || (state_q == ST_R_DATA)) : 1'bz;
    assign DEVSEL = ctl_oe ? (state_q == ST_BACKOFF) : 1'bz;
    assign STOP   = ctl_oe ? (state_q != ST_DISC) : 1'bz;
    assign AD     = (state_q == ST_R_DATA) ? mem_q[idx_q] : 32'bz;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: randomized initiator driving pci_target_mem, scoreboard-checked against an array model.
// Latency: initiator timing is fixed per transaction; the monitor checks each completed transfer as it happens.
// Backpressure: random IRDY wait states; bursts past the last word expect a STOP disconnect.
module tb_pci_target_mem;
    localparam logic [31:0] BASE  = 32'h0000_0010;
    localparam int          DEPTH = 4;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cbe;
    logic        frame;
    logic        irdy;
    logic        ad_oe;
    logic [31:0] ad_drv;

    // Bus lines carry pull-ups, so a released line reads as 1.
    tri1 [31:0] ad;
    tri1        trdy;
    tri1        devsel;
    tri1        stop;

    assign ad = ad_oe ? ad_drv : 32'bz;

    pci_target_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .AD     (ad),
        .C_BE   (cbe),
        .Frame  (frame),
        .IRDY   (irdy),
        .TRDY   (trdy),
        .DEVSEL (devsel),
        .STOP   (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_released(input string name, input bit chk_ad);
        check({name, "_trdy"}, 32'(trdy), 32'd1);
        check({name, "_devsel"}, 32'(devsel), 32'd1);
        check({name, "_stop"}, 32'(stop), 32'd1);
        if (chk_ad) check({name, "_ad"}, ad, ONES);
    endtask

    // Monitor: every cycle where a transfer completes at the next edge pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && !irdy && trdy == 1'b0 && devsel == 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_xfer actual=transfer required=none ad=%h", ad);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.rd) check("rd_data", ad, e.dat);
            end
        end
    end

    // One initiator transaction. The model decides hit/miss and how many transfers the target accepts.
    task automatic xact(input logic [3:0] cmd, input logic [31:0] addr, input int len, input int waitp,
                        input logic [31:0] dat0, input logic [3:0] be0, input bit rnd);
        bit          wr, rd, hit;
        int          idx, n_eff, w;
        logic [31:0] dat;
        logic [3:0]  be;
        wr  = (cmd == 4'b0111);
        rd  = (cmd == 4'b0110);
        hit = (wr || rd) && (addr[1:0] == 2'b00) && (addr >= BASE) && (addr < BASE + 4 * DEPTH);
        idx = hit ? int'((addr - BASE) >> 2) : 0;
        n_eff = len;
        if (hit && (DEPTH - idx) < len) n_eff = DEPTH - idx;

        cyc();
        frame = 1'b0; irdy = 1'b1; ad_oe = 1'b1; ad_drv = addr; cbe = cmd;

        if (hit && rd) begin
            cyc();
            ad_oe = 1'b0; irdy = 1'b1; cbe = 4'h0;
            smp();
            check("turn_devsel", 32'(devsel), 32'd0);
            check("turn_trdy", 32'(trdy), 32'd1);
            check("turn_ad", ad, ONES);
        end

        for (int p = 0; p < n_eff; p++) begin
            if (rnd) begin
                dat = $urandom & 32'hFFFF_FFFE;
                be  = 4'($urandom);
            end else begin
                dat = dat0;
                be  = be0;
            end
            w = ($urandom_range(0, 99) < waitp) ? int'($urandom_range(1, 2)) : 0;
            for (int k = 0; k < w; k++) begin
                cyc();
                irdy = 1'b1; frame = 1'b0; ad_oe = wr; ad_drv = $urandom; cbe = 4'($urandom);
                smp();
                if (hit) begin
                    check("wait_devsel", 32'(devsel), 32'd0);
                    check("wait_trdy", 32'(trdy), 32'd0);
                    if (rd) check("wait_ad", ad, ref_mem[idx + p]);
                end else begin
                    check_released("miss_wait", rd);
                end
            end
            cyc();
            irdy = 1'b0; frame = (p == len - 1); ad_oe = wr; ad_drv = dat;
            cbe = wr ? be : 4'($urandom);
            if (hit && wr) begin
                exp_q.push_back('{rd: 1'b0, dat: dat});
                for (int b = 0; b < 4; b++) begin
                    if (!be[b]) ref_mem[idx + p][8*b +: 8] = dat[8*b +: 8];
                end
            end else if (hit) begin
                exp_q.push_back('{rd: 1'b1, dat: ref_mem[idx + p]});
            end
            smp();
            if (hit) begin
                check("data_devsel", 32'(devsel), 32'd0);
                check("data_trdy", 32'(trdy), 32'd0);
            end else begin
                check_released("miss_data", rd);
            end
        end

        cyc();
        frame = 1'b1; irdy = 1'b1; ad_oe = 1'b0;
        smp();
        if (hit && n_eff < len) begin
            check("disc_stop", 32'(stop), 32'd0);
            check("disc_devsel", 32'(devsel), 32'd0);
            check("disc_trdy", 32'(trdy), 32'd1);
            check("disc_ad", ad, ONES);
            cyc();
            smp();
            check_released("disc_backoff", 1'b1);
        end else begin
            check_released("tail", 1'b1);
        end

        cyc();
        smp();
        check_released("idle", 1'b1);
        check("xfer_count_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic read_all();
        xact(4'b0110, BASE, DEPTH, 0, 32'h0, 4'h0, 1'b1);
    endtask

    initial begin
        logic [3:0]  cmd;
        logic [31:0] addr;
        int          r;

        checks = 0; failures = 0;
        rst_n = 1'b0; frame = 1'b1; irdy = 1'b1; ad_oe = 1'b0; ad_drv = '0; cbe = 4'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        smp();
        check_released("reset", 1'b1);
        cyc();
        rst_n = 1'b1;
        cyc();

        read_all();

        // Single write, byte-enable write, then a two-phase burst read of both.
        xact(4'b0111, 32'h10, 1, 0, 32'hAAAA_AAAA, 4'b0000, 1'b0);
        xact(4'b0111, 32'h14, 1, 0, 32'h1234_5678, 4'b0011, 1'b0);
        xact(4'b0110, 32'h10, 2, 0, 32'h0, 4'h0, 1'b1);

        // Write burst with wait states, then boundary disconnect from word 2.
        xact(4'b0111, 32'h10, 4, 100, 32'h0, 4'h0, 1'b1);
        read_all();
        xact(4'b0111, 32'h18, 3, 0, 32'h0, 4'h0, 1'b1);
        read_all();

        // Misses: below window, unsupported command, misaligned, above window.
        xact(4'b0111, 32'h00, 2, 0, 32'h0, 4'h0, 1'b1);
        xact(4'b1100, 32'h10, 2, 0, 32'h0, 4'h0, 1'b1);
        xact(4'b0110, 32'h12, 2, 0, 32'h0, 4'h0, 1'b1);
        xact(4'b0110, 32'h20, 1, 0, 32'h0, 4'h0, 1'b1);
        read_all();

        // Frame falling during the BACKOFF cycle must not be decoded.
        cyc();
        frame = 1'b0; irdy = 1'b1; ad_oe = 1'b1; ad_drv = BASE + 32'd4; cbe = 4'b0111;
        cyc();
        frame = 1'b1; irdy = 1'b0; ad_drv = 32'h0BAD_F00C; cbe = 4'h0;
        exp_q.push_back('{rd: 1'b0, dat: 32'h0BAD_F00C});
        ref_mem[1] = 32'h0BAD_F00C;
        cyc();
        frame = 1'b0; irdy = 1'b1; ad_drv = BASE; cbe = 4'b0111;
        cyc();
        frame = 1'b1; irdy = 1'b0; ad_drv = 32'h5555_5554; cbe = 4'h0;
        smp();
        check("b2b_devsel", 32'(devsel), 32'd1);
        check("b2b_trdy", 32'(trdy), 32'd1);
        cyc();
        irdy = 1'b1; ad_oe = 1'b0;
        smp();
        check_released("b2b_after", 1'b1);
        read_all();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            r   = int'($urandom_range(0, 99));
            cmd = (r < 45) ? 4'b0111 : (r < 90) ? 4'b0110 : 4'($urandom_range(8, 15));
            r   = int'($urandom_range(0, 99));
            if (r < 85) addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r < 90) addr = BASE - 32'd4;
            else if (r < 95) addr = BASE + 32'(4 * DEPTH);
            else addr = BASE + 32'd2;
            xact(cmd, addr, int'($urandom_range(1, 5)), 30, 32'h0, 4'h0, 1'b1);
        end
        read_all();

        // Reset in the middle of a read burst releases the bus at once and clears memory.
        cyc();
        frame = 1'b0; irdy = 1'b1; ad_oe = 1'b1; ad_drv = BASE; cbe = 4'b0110;
        cyc();
        ad_oe = 1'b0; cbe = 4'h0;
        cyc();
        irdy = 1'b0;
        exp_q.push_back('{rd: 1'b1, dat: ref_mem[0]});
        smp();
        cyc();
        irdy = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_released("mid_reset", 1'b1);
        frame = 1'b1; irdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        check("rst_xfer_left", 32'(exp_q.size()), 32'd0);
        cyc();
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pci_target_mem.md
Name: pci_target_mem

Overview:
PCI-style bus target (responder) holding a small word-addressed memory. It answers the single-write and burst read/write transactions issued by the existing PCI_DEV initiators on the shared AD/C_BE/Frame/IRDY bus. It drives the bus-side handshake (DEVSEL, TRDY, STOP) that the bench currently ties high. It sits on the same bus as the initiators, arbiter and decoder, one instance per target address window.

Parameters:
BASE_ADDR, 32'h0000_0010, byte address of word 0; must be 4-byte aligned.
DEPTH, 4, number of 32-bit words; power of two, 2..256.

Ports:
CLK  input  1  bus clock; all state changes on rising edge.
RST_N  input  1  asynchronous active-low reset.
AD  inout  32  multiplexed address/data.
C_BE  input  4  command in the address phase; active-low byte enables in data phases.
Frame  input  1  active-low; initiator transaction in progress.
IRDY  input  1  active-low initiator ready.
TRDY  output  1  active-low target ready; tri-state.
DEVSEL  output  1  active-low device select; tri-state.
STOP  output  1  active-low target disconnect request; tri-state.

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; TRDY, DEVSEL, STOP, AD released to z; all memory words cleared to 0. Reset mid-transaction releases the bus immediately. No recovery cycle.
- Commands: 4'b0111 = memory write, 4'b0110 = memory read. All other commands are ignored.
- Hit: address-phase AD in [BASE_ADDR, BASE_ADDR+4*DEPTH-1], AD[1:0]==2'b00, and a supported command. Word index = (AD-BASE_ADDR)>>2, width log2(DEPTH).
- Address phase: the edge in IDLE where Frame==0 and Frame was 1 on the previous edge. AD and C_BE are latched there.
- IDLE -> W_DATA on a hit with write. IDLE -> R_TURN on a hit with read. IDLE -> BUSY on a miss or unsupported command.
- BUSY: outputs stay z. -> IDLE on the first edge with Frame==1 and IRDY==1.
- W_DATA: DEVSEL=0 and TRDY=0, starting the cycle after the address phase (fast decode). On each edge with IRDY==0 and TRDY==0:
  - write AD bytes into mem[idx] for each C_BE[i]==0; bytes with C_BE[i]==1 are unchanged;
  - then idx+1.
- R_TURN: exactly one cycle; DEVSEL=0, TRDY=1, AD not driven (turnaround). -> R_DATA.
- R_DATA: AD driven with mem[idx] and TRDY=0. On each edge with IRDY==0:
  - transfer completes and idx+1;
  - AD shows the new word in the next cycle;
  - C_BE is ignored and all 4 bytes are returned.
- IRDY==1 in W_DATA or R_DATA inserts a wait state: no transfer, outputs held.
- Normal end: a transfer that completes with Frame==1 is the last one. -> BACKOFF.
- Boundary disconnect: a transfer completes at idx==DEPTH-1 with Frame still 0.
  - No wrap. -> DISC.
  - DISC: STOP=0, TRDY=1, DEVSEL=0, AD released; held until Frame==1, then -> BACKOFF.
- BACKOFF: one cycle driving DEVSEL=1, TRDY=1, STOP=1 (sustained tri-state high); AD released. Then all released to z. -> IDLE.
- DEVSEL, TRDY and STOP are driven only from the cycle after the address phase through BACKOFF; they are z otherwise. AD is driven only in R_DATA.
- Simultaneous events:
  - A new Frame falling in the BACKOFF cycle is not decoded. Frame must be seen at 1 in IDLE first.
  - A last transfer (Frame==1) at idx==DEPTH-1 goes to BACKOFF, not DISC.

Test Plan:
- Reset, then single write: addr 32'h10, cmd 0111, data 32'hAAAA_AAAA, C_BE 4'b0000, IRDY low -> DEVSEL/TRDY low the cycle after the address phase; mem[0]=AAAA_AAAA; one BACKOFF cycle high, then z.
- Byte-enable write: addr 32'h14, data 32'h1234_5678, C_BE 4'b0011 -> mem[1]=32'h1234_0000.
- Burst read: addr 32'h10, cmd 0110, IRDY low, Frame raised with the 2nd data phase.
  - Cycle after address: turnaround, AD=z, TRDY=1.
  - Then AD=AAAA_AAAA, then 1234_0000, each with TRDY=0.
- Wait states: write burst with IRDY high for 2 cycles mid-burst -> no memory update during the waits; idx is not advanced.
- Boundary: write burst at 32'h18 with Frame held low for 3 data phases -> mem[2], mem[3] written; STOP=0 on the 3rd phase; no write to mem[0].
- Miss: addr 32'h00 or cmd 4'b1100 -> DEVSEL, TRDY, STOP, AD stay z for the whole transaction; memory unchanged; reset asserted mid-burst releases all outputs immediately.
